// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: word width, access-size and FSM state
// encodings, and the misalignment helper used when DMEM_MISALIGN_CHK_EN is defined.
package dmem_responder_pkg;

  localparam int unsigned Width = 64;

  typedef enum logic [1:0] {
    SzB = 2'd0,
    SzH = 2'd1,
    SzW = 2'd2,
    SzD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  // True when the low address bits are not a multiple of the access size.
  function automatic logic is_misaligned(logic [2:0] lo, size_e size);
    logic [2:0] span;
    unique case (size)
      SzB:     span = 3'b000;
      SzH:     span = 3'b001;
      SzW:     span = 3'b011;
      default: span = 3'b111;
    endcase
    return |(lo & span);
  endfunction

endpackage

// File: rtl/dmem_sram_array.sv
// DEPTH x DATA_W word array with per-byte-lane write enables and a registered read port.
// Contents are never reset.
module dmem_sram_array #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic                       clk_i,
  input  logic [DATA_W/8-1:0]        be_i,
  input  logic                       re_i,
  input  logic [$clog2(DEPTH)-1:0]   addr_i,
  input  logic [DATA_W-1:0]          wdata_i,
  output logic [DATA_W-1:0]          rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DATA_W / 8; i++) begin
      if (be_i[i]) begin
        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: one request at a time, response RD_LAT cycles after accept,
// held until consumed. Define DMEM_MISALIGN_CHK_EN to flag and suppress misaligned accesses.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DATA_W = Width,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned RD_LAT = 2
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [1:0]          req_size,
  input  logic [DATA_W/8-1:0] req_wmask,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int unsigned NumLanes = DATA_W / 8;
  localparam int unsigned IdxW     = $clog2(DEPTH);
  localparam int unsigned CntW     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic                rsp_valid_q;
  logic                load_ok_q;
  logic                err_q;

  logic                accept;
  logic                misaligned;
  logic [IdxW-1:0]     word_idx;
  logic [NumLanes-1:0] lane_we;
  logic [DATA_W-1:0]   sram_rdata;

  assign req_ready = (state_q == StIdle) | ((state_q == StResp) & rsp_ready);
  // No accepts while reset is asserted, so nothing is written during reset.
  assign accept    = req_valid & req_ready & ~sys_rst;
  assign word_idx  = req_addr[IdxW+2:3];

`ifdef DMEM_MISALIGN_CHK_EN
  assign misaligned = is_misaligned(req_addr[2:0], size_e'(req_size));
`else
  assign misaligned = 1'b0;
`endif

  assign lane_we = (accept & req_we & ~misaligned) ? req_wmask : '0;

  // Upper address bits wrap; low bits and size only matter to the misalign check.
  logic unused_addr;
  assign unused_addr = ^{req_addr[ADDR_W-1:IdxW+3], req_addr[2:0], req_size};

  dmem_sram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_sram (
    .clk_i   (sys_clk),
    .be_i    (lane_we),
    .re_i    (accept & ~req_we),
    .addr_i  (word_idx),
    .wdata_i (req_wdata),
    .rdata_o (sram_rdata)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      load_ok_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (rsp_valid_q && rsp_ready) begin
        state_q     <= StIdle;
        rsp_valid_q <= 1'b0;
      end
      if (accept) begin
        load_ok_q <= ~req_we & ~misaligned;
        err_q     <= misaligned;
        if (RD_LAT == 1) begin
          state_q     <= StResp;
          rsp_valid_q <= 1'b1;
        end else begin
          state_q <= StWait;
          cnt_q   <= CntW'(RD_LAT - 1);
        end
      end else if (state_q == StWait) begin
        if (cnt_q == '0) begin
          state_q     <= StResp;
          rsp_valid_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = load_ok_q ? sram_rdata : '0;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (default parameters); expectations follow DMEM_MISALIGN_CHK_EN.
module tb_dmem_responder;

  logic        sys_clk;
  logic        sys_rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [63:0] req_addr;
  logic [1:0]  req_size;
  logic [7:0]  req_wmask;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  int checks;
  int errors;

  dmem_responder dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .req_wmask (req_wmask),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Present a request and hold it until the accept edge; returns #1 after that edge.
  task automatic send(input logic we, input logic [63:0] addr, input logic [1:0] size,
                      input logic [7:0] wmask, input logic [63:0] wdata);
    int n;
    @(negedge sys_clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_size  = size;
    req_wmask = wmask;
    req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge sys_clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL send_ready: req_ready=%b required 1 (addr %h)", req_ready, addr);
    end
    @(posedge sys_clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Wait for the response, capture it and consume it; lat counts edges from accept.
  task automatic get_rsp(output int lat, output logic [63:0] rdata, output logic err);
    lat = 0;
    do begin
      @(posedge sys_clk);
      #1;
      lat++;
    end while (!rsp_valid && lat < 20);
    rdata = rsp_rdata;
    err   = rsp_err;
    if (!rsp_valid) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: rsp_valid=%b required 1 within 20 cycles", rsp_valid);
    end
    rsp_ready = 1'b1;
    @(posedge sys_clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst   = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_size  = '0;
    req_wmask = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_rsp_valid: got %b required 0", rsp_valid);
      end
      checks++;
      if (req_ready !== 1'b1) begin
        errors++;
        $display("FAIL rst_req_ready: got %b required 1", req_ready);
      end
      checks++;
      if (rsp_err !== 1'b0) begin
        errors++;
        $display("FAIL rst_rsp_err: got %b required 0", rsp_err);
      end
    end
    sys_rst = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (rsp_rdata !== 64'h0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_rst_idle: rdata=%h valid=%b ready=%b required 0/0/1",
               rsp_rdata, rsp_valid, req_ready);
    end
  endtask

  task automatic test_store_load();
    int          lat;
    logic [63:0] rd;
    logic        er;
    send(1'b1, 64'h40, 2'd3, 8'hFF, 64'h1122334455667788);
    get_rsp(lat, rd, er);
    checks++;
    if (lat !== 2 || rd !== 64'h0 || er !== 1'b0) begin
      errors++;
      $display("FAIL store_d_rsp: lat=%0d rdata=%h err=%b required 2/0/0", lat, rd, er);
    end
    send(1'b0, 64'h40, 2'd3, 8'h00, 64'h0);
    get_rsp(lat, rd, er);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL load_latency: got %0d required 2", lat);
    end
    checks++;
    if (rd !== 64'h1122334455667788 || er !== 1'b0) begin
      errors++;
      $display("FAIL load_d: rdata=%h err=%b required 1122334455667788/0", rd, er);
    end
  endtask

  task automatic test_byte_store();
    int          lat;
    logic [63:0] rd;
    logic        er;
    send(1'b1, 64'h43, 2'd0, 8'h08, 64'h00000000AB000000);
    get_rsp(lat, rd, er);
    send(1'b0, 64'h40, 2'd3, 8'h00, 64'h0);
    get_rsp(lat, rd, er);
    checks++;
    if (rd !== 64'h11223344AB667788) begin
      errors++;
      $display("FAIL byte_store: rdata=%h required 11223344ab667788", rd);
    end
  endtask

  task automatic test_backpressure();
    int          n;
    int          lat;
    logic [63:0] rd;
    logic        er;
    send(1'b0, 64'h40, 2'd3, 8'h00, 64'h0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_rsp_timeout: rsp_valid=%b required 1", rsp_valid);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 64'h11223344AB667788 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: valid=%b rdata=%h ready=%b required 1/11223344ab667788/0",
                 rsp_valid, rsp_rdata, req_ready);
      end
    end
    @(negedge sys_clk);
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 64'h80;
    req_size  = 2'd3;
    req_wmask = 8'hFF;
    req_wdata = 64'h0F0E0D0C0B0A0908;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_comb: req_ready=%b required 1", req_ready);
    end
    @(posedge sys_clk);
    #1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_consumed: rsp_valid=%b required 0", rsp_valid);
    end
    get_rsp(lat, rd, er);
    checks++;
    if (lat !== 2 || rd !== 64'h0 || er !== 1'b0) begin
      errors++;
      $display("FAIL bp_same_cycle_store: lat=%0d rdata=%h err=%b required 2/0/0", lat, rd, er);
    end
    send(1'b0, 64'h80, 2'd3, 8'h00, 64'h0);
    get_rsp(lat, rd, er);
    checks++;
    if (rd !== 64'h0F0E0D0C0B0A0908) begin
      errors++;
      $display("FAIL bp_store_data: rdata=%h required 0f0e0d0c0b0a0908", rd);
    end
  endtask

  task automatic test_wrap();
    int          lat;
    logic [63:0] rd;
    logic        er;
    send(1'b1, 64'h2000, 2'd3, 8'hFF, 64'hA5A5_5A5A_0123_4567);
    get_rsp(lat, rd, er);
    send(1'b0, 64'h0, 2'd3, 8'h00, 64'h0);
    get_rsp(lat, rd, er);
    checks++;
    if (rd !== 64'hA5A5_5A5A_0123_4567) begin
      errors++;
      $display("FAIL wrap: rdata=%h required a5a55a5a01234567", rd);
    end
  endtask

  task automatic test_misalign();
    int          lat;
    logic [63:0] rd;
    logic        er;
    logic        exp_err;
    logic [63:0] exp_word;
`ifdef DMEM_MISALIGN_CHK_EN
    exp_err  = 1'b1;
    exp_word = 64'h11223344AB667788;
`else
    exp_err  = 1'b0;
    exp_word = 64'h1122DEADBEEF7788;
`endif
    send(1'b1, 64'h42, 2'd2, 8'h3C, 64'h0000DEADBEEF0000);
    get_rsp(lat, rd, er);
    checks++;
    if (er !== exp_err || rd !== 64'h0 || lat !== 2) begin
      errors++;
      $display("FAIL mis_store_rsp: err=%b rdata=%h lat=%0d required %b/0/2", er, rd, lat, exp_err);
    end
    send(1'b0, 64'h40, 2'd3, 8'h00, 64'h0);
    get_rsp(lat, rd, er);
    checks++;
    if (rd !== exp_word || er !== 1'b0) begin
      errors++;
      $display("FAIL mis_store_word: rdata=%h err=%b required %h/0", rd, er, exp_word);
    end
    send(1'b0, 64'h41, 2'd1, 8'h00, 64'h0);
    get_rsp(lat, rd, er);
    checks++;
    if (er !== exp_err || rd !== (exp_err ? 64'h0 : exp_word) || lat !== 2) begin
      errors++;
      $display("FAIL mis_load: err=%b rdata=%h lat=%0d required err %b", er, rd, lat, exp_err);
    end
    send(1'b0, 64'h44, 2'd2, 8'h00, 64'h0);
    get_rsp(lat, rd, er);
    checks++;
    if (er !== 1'b0 || rd !== exp_word) begin
      errors++;
      $display("FAIL aligned_w_load: err=%b rdata=%h required 0/%h", er, rd, exp_word);
    end
  endtask

  task automatic test_reset_mid();
    int          lat;
    logic [63:0] rd;
    logic        er;
    send(1'b1, 64'hC0, 2'd3, 8'hFF, 64'hCAFEF00D12345678);
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL rst_mid_drop: valid=%b ready=%b required 0/1", rsp_valid, req_ready);
      end
    end
    send(1'b0, 64'hC0, 2'd3, 8'h00, 64'h0);
    get_rsp(lat, rd, er);
    checks++;
    if (rd !== 64'hCAFEF00D12345678) begin
      errors++;
      $display("FAIL rst_mid_store_kept: rdata=%h required cafef00d12345678", rd);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_store_load();
    test_byte_store();
    test_backpressure();
    test_wrap();
    test_misalign();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
